mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Multi-cycle, word-addressed main-memory responder. It sits on the far side of the
//  CPU memory-request interface and answers the fetch/memory-stage initiators.
//  It accepts one request per cycle, performs writes immediately, and returns read data
//  a fixed LATENCY cycles later with a valid strobe. This supplies the stall/latency
//  behaviour that the pipelined CPU and a future cache-fill FSM must tolerate.
// PARAMETERS
//  LATENCY  4   cycles from request accept edge to data_valid; legal range 1..8
//  AW      16   byte-address width; array depth = 2**(AW-1) 16-bit words
//  DW      16   data width (fixed 16 for this ISA)
// PORTS
//  clk         in   1   system clock, rising-edge
//  rst_n       in   1   asynchronous active-low reset
//  enable      in   1   request present this cycle
//  wr          in   1   1 = write, 0 = read (qualified by enable)
//  burst       in   1   read burst request (used only with MEM_BURST_EN)
//  addr        in   AW  byte address; addr[0] ignored (word aligned)
//  data_in     in   DW  write data
//  ready       out  1   request accepted this cycle if enable&ready
//  data_out    out  DW  read data, meaningful only when data_valid=1
//  data_valid  out  1   read data returned this cycle
// BEHAVIOUR
//  - Clock clk; reset rst_n is asynchronous, active-low.
//  - Reset values: data_valid=0, data_out=0, ready=1, all in-flight pipeline valid bits=0,
//    burst counter=0. Array contents are not reset; the bench preloads them.
//  - Accept: a request is taken at a rising edge when enable=1 and ready=1; otherwise it is dropped.
//  - Write accepted at edge N: mem[addr[AW-1:1]] <= data_in at edge N. No response is
//    produced, and data_valid is not asserted for a write.
//  - Read accepted at edge N: the array is sampled at edge N. The value includes every write
//    accepted at edges < N. data_out/data_valid are driven during the cycle after edge
//    N+LATENCY-1, i.e. LATENCY cycles after the accept. LATENCY=1 means valid the next cycle.
//  - Pipelined: a read on every cycle yields data_valid on every cycle, in request order.
//    Reads and writes may interleave freely.
//  - Implementation: shift pipeline of depth LATENCY holding {valid, data}. data_out holds its
//    last value when data_valid=0.
//  - Address wrap: none needed; full AW-bit space is backed. addr[0]=1 reads/writes same word.
//  - Reset asserted mid-operation: all in-flight reads are discarded. No data_valid follows
//    reset release until a new read is accepted. Array writes already done persist.
// CONFIGURATION
//  MEM_BURST_EN defined:
//   - Read with burst=1 accepted at edge N returns 4 words from base = {addr[AW-1:3],3'b000}.
//     Word order is base, base+2, base+4, base+6, on 4 consecutive cycles.
//     The first word is valid LATENCY cycles after N.
//   - ready=0 from cycle after N until the cycle the last burst word is valid (inclusive).
//     ready returns to 1 the following cycle. Requests during ready=0 are ignored.
//   - burst=1 on a write is treated as a single write.
//   - FSM: IDLE -> BURST (on burst read accept) -> IDLE (after 4th word issued).
//     A 2-bit beat counter tracks the words; reset returns the FSM to IDLE.
//   - Earlier single reads still in flight complete before the burst words.
//  MEM_BURST_EN undefined: burst input ignored, ready tied 1, no FSM.
// TESTING
//  1 Reset: rst_n=0 async mid-cycle -> data_valid=0, data_out=0x0000, ready=1 immediately.
//  2 Write then read: write 0xBEEF @0x0010 at edge 1, read @0x0010 at edge 2 (LATENCY=4)
//    -> data_valid=1, data_out=0xBEEF in the cycle after edge 5 only.
//  3 Back-to-back: preload mem[0..3]=0x1111,0x2222,0x3333,0x4444, reads @0,2,4,6 on edges 1-4
//    -> data_valid high 4 consecutive cycles, data 0x1111..0x4444 in order.
//  4 Odd address: write 0x00A5 @0x0021, read @0x0020 -> 0x00A5.
//  5 Reset mid-flight: read accepted at edge 1, rst_n pulsed low at cycle 2
//    -> data_valid never asserts.
//  6 (MEM_BURST_EN) burst read @0x000C with mem[4..7]=0xA0,0xA1,0xA2,0xA3
//    -> 0x00A0..0x00A3 on 4 consecutive cycles from LATENCY after accept.
//    A read presented while ready=0 produces no response.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory answering CPU fetch/memory-stage requests (burst reads with MEM_BURST_EN).
// Latency: writes land at the accept edge; read data returns LATENCY cycles after accept (LATENCY 1..8).
// Backpressure: ready is tied high, except with MEM_BURST_EN where it drops from burst accept until the last beat is out.
module mem_responder #(
  parameter int LATENCY = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          wr,
  input  logic          burst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic          ready,
  output logic [DW-1:0] data_out,
  output logic          data_valid
);
  localparam int WAW   = AW - 1;
  localparam int DEPTH = 1 << WAW;

  logic [DW-1:0]      mem [DEPTH];
  logic [WAW-1:0]     word_addr;
  logic               addr_unused;
  logic               accept;
  logic               wr_en;
  logic               rd_issue;
  logic [WAW-1:0]     rd_addr;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [DW-1:0]      dat_q [LATENCY];
  logic [DW-1:0]      dat_d [LATENCY];

  // addr[0] is a byte offset inside a 16-bit word and never selects anything.
  assign word_addr   = addr[AW-1:1];
  assign addr_unused = addr[0];
  assign accept      = enable & ready & rst_n;
  assign wr_en       = accept & wr;

`ifdef MEM_BURST_EN
  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t             state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic [WAW-3:0]     base_q, base_d;
  logic [LATENCY-1:0] bst_q, bst_d;
  logic               rd_bst;

  // Burst beats are tagged in the pipe so ready stays low until the final beat has been presented.
  assign ready = (state_q == S_IDLE) && (bst_q == '0);

  // Sequencer: choose the word entering the read pipe; a burst issues base+0 at accept, then three more beats.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    base_d   = base_q;
    rd_issue = 1'b0;
    rd_bst   = 1'b0;
    rd_addr  = word_addr;
    case (state_q)
      S_IDLE: begin
        if (accept && !wr) begin
          rd_issue = 1'b1;
          if (burst) begin
            rd_bst  = 1'b1;
            rd_addr = {word_addr[WAW-1:2], 2'b00};
            base_d  = word_addr[WAW-1:2];
            beat_d  = 2'd1;
            state_d = S_BURST;
          end
        end
      end
      S_BURST: begin
        rd_issue = 1'b1;
        rd_bst   = 1'b1;
        rd_addr  = {base_q, beat_q};
        beat_d   = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Burst tag shifts alongside the valid bits.
  always_comb begin
    bst_d    = bst_q;
    bst_d[0] = rd_bst;
    for (int i = 1; i < LATENCY; i++) bst_d[i] = bst_q[i-1];
  end

  // Sequencer and tag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      base_q  <= '0;
      bst_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      bst_q   <= bst_d;
    end
  end
`else
  logic burst_unused;

  // Single-word reads only; every request is taken.
  assign burst_unused = burst;
  assign ready        = 1'b1;
  assign rd_issue     = accept & ~wr;
  assign rd_addr      = word_addr;
`endif

  // Array write at the accept edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[rd_addr] <= data_in;
  end

  // Read pipe: valid walks one stage per cycle; data only moves with a valid bit, so the output stage holds.
  always_comb begin
    vld_d    = vld_q;
    dat_d    = dat_q;
    vld_d[0] = rd_issue;
    if (rd_issue) dat_d[0] = mem[rd_addr];
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
    end
  end

  // Pipe registers; reset discards every in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign data_valid = vld_q[LATENCY-1];
  assign data_out   = dat_q[LATENCY-1];
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios with literal expectations plus a randomized
// request stream checked every cycle against a queue-based response model.
module tb_mem_responder;
  localparam int LAT = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
`ifdef MEM_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          wr = 1'b0;
  logic          burst = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic          ready;
  logic [DW-1:0] data_out;
  logic          data_valid;

  mem_responder #(.LATENCY(LAT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .burst(burst),
    .addr(addr), .data_in(data_in), .ready(ready), .data_out(data_out),
    .data_valid(data_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted read becomes a list entry "edge index after which data is shown, data".
  typedef struct { int cyc; logic [15:0] dat; } rsp_t;
  rsp_t        rq[$];
  logic [15:0] mmem [int];
  int          e = 0;          // posedges seen while out of reset
  int          bend = -100;    // ready is low in the cycle after edges <= bend
  logic [15:0] last_out = '0;
  int          w, base;

  function automatic logic [15:0] mrd(input int wa);
    return mmem.exists(wa) ? mmem[wa] : 16'h0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq.delete();
      bend = -100;
      last_out = '0;
    end else begin
      e++;
      if (enable && (e - 1 > bend)) begin
        w = int'(addr) >> 1;
        if (wr) mmem[w] = data_in;
        else if (burst && BURST_EN) begin
          base = w & ~3;
          for (int k = 0; k < 4; k++) rq.push_back('{cyc: e + LAT - 1 + k, dat: mrd(base + k)});
          bend = e + LAT + 2;
        end else begin
          rq.push_back('{cyc: e + LAT - 1, dat: mrd(w)});
        end
      end
    end
  end

  // Compare process: every cycle, outputs must match the model.
  bit chk_en = 1'b0;
  bit ev;
  always @(negedge clk) begin
    if (chk_en) begin
      ev = (rq.size() > 0) && (rq[0].cyc == e);
      check("stream_valid", data_valid, ev);
      check("stream_ready", ready, !(e <= bend));
      if (ev) begin
        check("stream_data", data_out, rq[0].dat);
        last_out = rq[0].dat;
        void'(rq.pop_front());
      end else begin
        check("stream_hold", data_out, last_out);
      end
    end
  end

  // Present one request for one edge; called at a negedge, returns at the next negedge.
  task automatic req(input bit w_i, input bit b_i, input logic [15:0] a_i, input logic [15:0] d_i);
    enable = 1'b1; wr = w_i; burst = b_i; addr = a_i; data_in = d_i;
    @(negedge clk);
    enable = 1'b0; wr = 1'b0; burst = 1'b0;
  endtask

  logic [15:0] exp3;

  initial begin
    // Reset state
    #1;
    check("reset_valid", data_valid, 0);
    check("reset_data", data_out, 16'h0000);
    check("reset_ready", ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Preload words 0..31 with random data
    for (int i = 0; i < 32; i++) req(1'b1, 1'b0, 16'(2 * i), 16'($urandom));

    // Write then read, data appears exactly LAT cycles after accept and holds afterwards
    req(1'b1, 1'b0, 16'h0010, 16'hBEEF);
    req(1'b0, 1'b0, 16'h0010, 16'h0000);
    for (int i = 1; i <= LAT + 1; i++) begin
      check("t2_valid", data_valid, (i == LAT));
      if (i >= LAT) check("t2_data", data_out, 16'hBEEF);
      @(negedge clk);
    end

    // Back-to-back reads
    req(1'b1, 1'b0, 16'h0000, 16'h1111);
    req(1'b1, 1'b0, 16'h0002, 16'h2222);
    req(1'b1, 1'b0, 16'h0004, 16'h3333);
    req(1'b1, 1'b0, 16'h0006, 16'h4444);
    req(1'b0, 1'b0, 16'h0000, 16'h0000);
    req(1'b0, 1'b0, 16'h0002, 16'h0000);
    req(1'b0, 1'b0, 16'h0004, 16'h0000);
    req(1'b0, 1'b0, 16'h0006, 16'h0000);
    // now in the cycle after the 4th read's edge = LAT-1 cycles after the first read (LAT=4)
    for (int k = 0; k < 4; k++) begin
      exp3 = 16'h1111 * 16'(k + 1);
      check("t3_valid", data_valid, 1);
      check("t3_data", data_out, exp3);
      @(negedge clk);
    end
    check("t3_after", data_valid, 0);

    // Odd address maps to the same word
    req(1'b1, 1'b0, 16'h0021, 16'h00A5);
    req(1'b0, 1'b0, 16'h0020, 16'h0000);
    repeat (LAT - 1) @(negedge clk);
    check("t4_valid", data_valid, 1);
    check("t4_data", data_out, 16'h00A5);
    @(negedge clk);

    // Reset mid-flight discards the read
    req(1'b0, 1'b0, 16'h0010, 16'h0000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", data_valid, 0);
    check("t5_rst_data", data_out, 16'h0000);
    check("t5_rst_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      check("t5_no_valid", data_valid, 0);
      @(negedge clk);
    end
    // array survived reset
    req(1'b0, 1'b0, 16'h0010, 16'h0000);
    repeat (LAT - 1) @(negedge clk);
    check("t5_persist", data_out, 16'hBEEF);
    @(negedge clk);

`ifdef MEM_BURST_EN
    // Burst read of words 4..7 from an unaligned byte address, with a read ignored while busy
    req(1'b1, 1'b0, 16'h0008, 16'h00A0);
    req(1'b1, 1'b0, 16'h000A, 16'h00A1);
    req(1'b1, 1'b0, 16'h000C, 16'h00A2);
    req(1'b1, 1'b0, 16'h000E, 16'h00A3);
    req(1'b0, 1'b1, 16'h000C, 16'h0000);
    check("t6_busy", ready, 0);
    req(1'b0, 1'b0, 16'h0010, 16'h0000);
    repeat (LAT - 2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("t6_valid", data_valid, 1);
      check("t6_data", data_out, 16'(16'h00A0 + k));
      check("t6_ready_low", ready, 0);
      @(negedge clk);
    end
    check("t6_ready_back", ready, 1);
    check("t6_ignored", data_valid, 0);
`endif

    // Randomized stream, with one asynchronous reset pulse
    for (int it = 0; it < 400; it++) begin
      enable  = ($urandom % 4) != 0;
      wr      = ($urandom % 3) == 0;
      burst   = ($urandom % 8) == 0;
      addr    = 16'($urandom % 64);
      data_in = 16'($urandom);
      if (it == 200) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    enable = 1'b0; wr = 1'b0; burst = 1'b0;
    repeat (LAT + 8) @(negedge clk);
    check("drain", rq.size(), 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
